// File: rtl/lsu_dmem_master.sv
// MEM-stage load/store unit: one request in, memory beats out, one response pulse back.
// Ports: clk/reset, req_* pipeline request (valid/ready), rsp_* completion pulse,
//   busy, mem_* single-port data memory (cs/wr_en active-low, rd_en active-high,
//   mask encodes size+sign, mem_rdata combinational and right-aligned by the memory).
// Optional macro LSU_MISALIGN_EN: split misaligned H/W into byte or word beats;
//   when undefined every misaligned H/W access takes the error path.
module lsu_dmem_master #(
  parameter int DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        mem_cs,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_mask,
  input  logic [31:0] mem_rdata
);

  localparam logic [32:0] LIMIT = 33'(4 * DMEM_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t      state;
  logic [1:0]  beat;
  logic [1:0]  last;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  function automatic logic [3:0] lane_mask(input logic [2:0] f3);
    case (f3)
      3'b000:  lane_mask = 4'b0000;
      3'b001:  lane_mask = 4'b0001;
      3'b100:  lane_mask = 4'b0010;
      3'b101:  lane_mask = 4'b0100;
      default: lane_mask = 4'b1000;
    endcase
  endfunction

  function automatic logic [31:0] repl(input logic [1:0] sz,
                                       input logic [31:0] d);
    case (sz)
      2'b00:   repl = {4{d[7:0]}};
      2'b01:   repl = {2{d[15:0]}};
      default: repl = d;
    endcase
  endfunction

  function automatic logic [31:0] ext(input logic [2:0] f3,
                                      input logic [31:0] d);
    case (f3)
      3'b000:  ext = {{24{d[7]}}, d[7:0]};
      3'b001:  ext = {{16{d[15]}}, d[15:0]};
      3'b100:  ext = {24'd0, d[7:0]};
      3'b101:  ext = {16'd0, d[15:0]};
      default: ext = d;
    endcase
  endfunction

  // Request classification, evaluated on the incoming request.
  logic        ill;
  logic        oor;
  logic        mis;
  logic        err_req;
  logic [32:0] size_m1;

  always_comb begin
    ill = (req_funct3 == 3'b011) ||
          (req_funct3[2:1] == 2'b11) ||
          (req_we && req_funct3[2]);
    case (req_funct3[1:0])
      2'b00:   size_m1 = 33'd0;
      2'b01:   size_m1 = 33'd1;
      default: size_m1 = 33'd3;
    endcase
    // 33-bit sum so accesses near 0xFFFFFFFF cannot wrap into range
    oor = ({1'b0, req_addr} + size_m1) >= LIMIT;
    mis = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
          ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`ifdef LSU_MISALIGN_EN
    err_req = ill || oor;
`else
    err_req = ill || oor || mis;
`endif
  end

  // Next-beat plan: beat 0 from the request while idle,
  // beat+1 from the latched request while accessing.
  logic        p_we;
  logic [2:0]  p_f3;
  logic [31:0] p_addr;
  logic [31:0] p_wdata;
  logic [31:0] n_addr;
  logic [31:0] n_wdata;
  logic [3:0]  n_mask;
  logic [1:0]  n_last;
`ifdef LSU_MISALIGN_EN
  logic        split_q;
  logic        p_split;
  logic [1:0]  p_idx;
  logic [7:0]  p_byte;
  logic [31:0] buf_q;
`endif

  always_comb begin
    p_we    = req_we;
    p_f3    = req_funct3;
    p_addr  = req_addr;
    p_wdata = req_wdata;
    if (state != IDLE) begin
      p_we    = we_q;
      p_f3    = f3_q;
      p_addr  = addr_q;
      p_wdata = wdata_q;
    end
    n_addr  = p_addr;
    n_mask  = lane_mask(p_f3);
    n_wdata = p_we ? repl(p_f3[1:0], p_wdata) : 32'd0;
    n_last  = 2'd0;
`ifdef LSU_MISALIGN_EN
    p_split = (state == IDLE) ? mis : split_q;
    p_idx   = (state == IDLE) ? 2'd0 : beat + 2'd1;
    p_byte  = 8'(p_wdata >> {p_idx, 3'b000});
    if (p_split) begin
      unique case (1'b1)
        (p_f3[1:0] == 2'b01): begin
          n_addr  = p_addr + 32'(p_idx);
          n_mask  = p_we ? 4'b0000 : 4'b0010;
          n_wdata = p_we ? {4{p_byte}} : 32'd0;
          n_last  = 2'd1;
        end
        (p_f3[1:0] != 2'b01) && !p_we: begin
          n_addr  = {p_addr[31:2], 2'b00} + {28'd0, p_idx, 2'b00};
          n_mask  = 4'b1000;
          n_wdata = 32'd0;
          n_last  = 2'd1;
        end
        (p_f3[1:0] != 2'b01) && p_we: begin
          n_addr  = p_addr + 32'(p_idx);
          n_mask  = 4'b0000;
          n_wdata = {4{p_byte}};
          n_last  = 2'd3;
        end
      endcase
    end
`endif
  end

  // Load result formed on the final beat from the live read data
  // plus whatever the first beat captured.
  logic [31:0] r_data;

  always_comb begin
    r_data = ext(f3_q, mem_rdata);
`ifdef LSU_MISALIGN_EN
    if (split_q) begin
      if (f3_q[1:0] == 2'b01)
        r_data = ext(f3_q, {16'd0, mem_rdata[7:0], buf_q[7:0]});
      else
        r_data = 32'({mem_rdata, buf_q} >> {addr_q[1:0], 3'b000});
    end
`endif
    if (we_q) r_data = 32'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      beat      <= 2'd0;
      last      <= 2'd0;
      we_q      <= 1'b0;
      f3_q      <= 3'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      mem_cs    <= 1'b1;
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b1;
      mem_mask  <= 4'b1000;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
`ifdef LSU_MISALIGN_EN
      split_q   <= 1'b0;
      buf_q     <= 32'd0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'd0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            f3_q      <= req_funct3;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            busy      <= 1'b1;
`ifdef LSU_MISALIGN_EN
            split_q   <= mis;
`endif
            if (err_req) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              state     <= ACCESS;
              beat      <= 2'd0;
              last      <= n_last;
              mem_cs    <= 1'b0;
              mem_rd_en <= ~req_we;
              mem_wr_en <= ~req_we;
              mem_addr  <= n_addr;
              mem_wdata <= n_wdata;
              mem_mask  <= n_mask;
            end
          end
        end
        ACCESS: begin
`ifdef LSU_MISALIGN_EN
          if (beat == 2'd0) buf_q <= mem_rdata;
`endif
          if (beat == last) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= r_data;
            mem_cs    <= 1'b1;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b1;
            mem_mask  <= 4'b1000;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
          end else begin
            beat      <= beat + 2'd1;
            mem_addr  <= n_addr;
            mem_wdata <= n_wdata;
            mem_mask  <= n_mask;
          end
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Randomized bench for lsu_dmem_master against a byte-array reference model.
// Includes a behavioural data memory honouring the mask/lane encoding.
module tb_lsu_dmem_master;

  localparam int DW = 64;
  localparam int NB = 4 * DW;
`ifdef LSU_MISALIGN_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        mem_cs;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_mask;
  logic [31:0] mem_rdata;

  lsu_dmem_master #(.DMEM_WORDS(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .mem_cs     (mem_cs),
    .mem_rd_en  (mem_rd_en),
    .mem_wr_en  (mem_wr_en),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_mask   (mem_mask),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural data memory
  logic [7:0]  dmem [NB];
  logic [7:0]  ref_b [NB];
  logic        mem_init;
  logic [31:0] mword;
  logic [7:0]  bsel;
  logic [15:0] hsel;

  always_comb begin
    mword = {dmem[{mem_addr[7:2], 2'd3}], dmem[{mem_addr[7:2], 2'd2}],
             dmem[{mem_addr[7:2], 2'd1}], dmem[{mem_addr[7:2], 2'd0}]};
    bsel = 8'(mword >> {mem_addr[1:0], 3'b000});
    hsel = 16'(mword >> {mem_addr[1], 4'b0000});
    case (mem_mask)
      4'b0000: mem_rdata = {{24{bsel[7]}}, bsel};
      4'b0010: mem_rdata = {24'd0, bsel};
      4'b0001: mem_rdata = {{16{hsel[15]}}, hsel};
      4'b0100: mem_rdata = {16'd0, hsel};
      default: mem_rdata = mword;
    endcase
  end

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < NB; i++) dmem[i] <= 8'(i * 37 + 11);
    end else if (!mem_cs && !mem_wr_en) begin
      case (mem_mask)
        4'b1000:
          for (int i = 0; i < 4; i++)
            dmem[{mem_addr[7:2], 2'b00} + 8'(i)] <= mem_wdata[8*i +: 8];
        4'b0001:
          for (int i = 0; i < 2; i++)
            dmem[{mem_addr[7:1], 1'b0} + 8'(i)] <=
              mem_wdata[16*mem_addr[1] + 8*i +: 8];
        default:
          dmem[mem_addr[7:0]] <= mem_wdata[8*mem_addr[1:0] +: 8];
      endcase
    end
  end

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
    logic        rd;
    logic        wr;
  } beat_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rdata;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] mask_of(input logic [2:0] f3);
    case (f3)
      3'b000:  return 4'b0000;
      3'b001:  return 4'b0001;
      3'b100:  return 4'b0010;
      3'b101:  return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  // One request end to end: predict, drive, watch beats, compare.
  task automatic do_op(input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    beat_t       eb[$];
    beat_t       gb[$];
    beat_t       b;
    int          sz, n, k, w;
    logic        ill, oor, mis, err, seen;
    logic [31:0] val, rd_e;
    longint      span;

    sz   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    ill  = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
           (we && (f3 == 3'b100 || f3 == 3'b101));
    span = longint'(a) + longint'(sz) - 1;
    oor  = span >= NB;
    mis  = (a % sz) != 0;
    err  = ill || oor || (mis && !MIS_EN);
    rd_e = 32'd0;
    if (!err) begin
      val = 32'd0;
      for (int i = 0; i < sz; i++) begin
        if (we) ref_b[int'(a) + i] = wd[8*i +: 8];
        else val |= 32'(ref_b[int'(a) + i]) << (8 * i);
      end
      if (!we)
        rd_e = (f3 == 3'b000) ? {{24{val[7]}}, val[7:0]} :
               (f3 == 3'b001) ? {{16{val[15]}}, val[15:0]} : val;
      b.rd = !we;
      b.wr = !we;
      if (!mis) begin
        b.a = a;
        b.m = mask_of(f3);
        b.d = (sz == 1) ? {4{wd[7:0]}} : (sz == 2) ? {2{wd[15:0]}} : wd;
        eb.push_back(b);
      end else if (sz == 2) begin
        for (int i = 0; i < 2; i++) begin
          b.a = a + 32'(i);
          b.m = we ? 4'b0000 : 4'b0010;
          b.d = {4{wd[8*i +: 8]}};
          eb.push_back(b);
        end
      end else if (!we) begin
        for (int i = 0; i < 2; i++) begin
          b.a = (a & ~32'd3) + 32'(4 * i);
          b.m = 4'b1000;
          b.d = 32'd0;
          eb.push_back(b);
        end
      end else begin
        for (int i = 0; i < 4; i++) begin
          b.a = a + 32'(i);
          b.m = 4'b0000;
          b.d = {4{wd[8*i +: 8]}};
          eb.push_back(b);
        end
      end
    end
    n = eb.size();

    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) check("ready_wait", req_ready, 1'b1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    // keep valid asserted with junk fields; a busy unit must ignore them
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 12) begin
      @(negedge clk);
      k++;
      if (k == 1) check("busy", busy, 1'b1);
      if (!mem_cs) begin
        b.a  = mem_addr;
        b.d  = mem_wdata;
        b.m  = mem_mask;
        b.rd = mem_rd_en;
        b.wr = mem_wr_en;
        gb.push_back(b);
      end
      if (rsp_valid) seen = 1'b1;
    end
    req_valid  = 1'b0;
    last_rdata = rsp_rdata;
    check("latency", k, err ? 1 : n + 1);
    check("rsp_err", rsp_err, err);
    check("rsp_rdata", rsp_rdata, rd_e);
    check("nbeats", gb.size(), n);
    for (int i = 0; i < n && i < gb.size(); i++) begin
      check("beat_addr", gb[i].a, eb[i].a);
      check("beat_mask", gb[i].m, eb[i].m);
      check("beat_rd_en", gb[i].rd, eb[i].rd);
      check("beat_wr_en", gb[i].wr, eb[i].wr);
      if (we) check("beat_wdata", gb[i].d, eb[i].d);
    end
    @(negedge clk);
    check("ready_back", req_ready, 1'b1);
    check("busy_idle", busy, 1'b0);
    check("rsp_pulse", rsp_valid, 1'b0);
    check("cs_idle", mem_cs, 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a;
    int          p;

    reset      = 1'b1;
    mem_init   = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    for (int i = 0; i < NB; i++) ref_b[i] = 8'(i * 37 + 11);
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_cs", mem_cs, 1'b1);
    check("rst_rd_en", mem_rd_en, 1'b0);
    check("rst_wr_en", mem_wr_en, 1'b1);
    check("rst_mask", mem_mask, 4'b1000);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    mem_init = 1'b0;
    reset    = 1'b0;
    @(negedge clk);

    do_op(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    do_op(1'b0, 3'b010, 32'h10, 32'h0);
    check("tp_lw", last_rdata, 32'hDEADBEEF);
    do_op(1'b1, 3'b010, 32'h20, 32'h000080F0);
    do_op(1'b0, 3'b000, 32'h20, 32'h0);
    check("tp_lb", last_rdata, 32'hFFFFFFF0);
    do_op(1'b0, 3'b100, 32'h20, 32'h0);
    check("tp_lbu", last_rdata, 32'h000000F0);
    do_op(1'b0, 3'b001, 32'h20, 32'h0);
    check("tp_lh", last_rdata, 32'hFFFF80F0);
    do_op(1'b0, 3'b101, 32'h20, 32'h0);
    check("tp_lhu", last_rdata, 32'h000080F0);
    do_op(1'b1, 3'b010, 32'h04, 32'h44332211);
    do_op(1'b1, 3'b010, 32'h08, 32'h88776655);
    do_op(1'b0, 3'b010, 32'h06, 32'h0);
    check("tp_lw_mis", last_rdata, MIS_EN ? 32'h66554433 : 32'h0);
    do_op(1'b1, 3'b001, 32'h03, 32'h0000BEEF);
    do_op(1'b0, 3'b101, 32'h03, 32'h0);
    check("tp_lhu_mis", last_rdata, MIS_EN ? 32'h0000BEEF : 32'h0);
    do_op(1'b0, 3'b010, 32'h100, 32'h0);
    do_op(1'b0, 3'b011, 32'h00, 32'h0);
    do_op(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0);
    do_op(1'b0, 3'b000, 32'hFF, 32'h0);
    do_op(1'b0, 3'b001, 32'hFF, 32'h0);
    do_op(1'b1, 3'b010, 32'hFC, 32'h12345678);
    do_op(1'b1, 3'b100, 32'h30, 32'h0);

    for (int t = 0; t < 250; t++) begin
      we = 1'($urandom);
      p  = $urandom_range(0, 9);
      if (p == 0) f3 = 3'($urandom);
      else begin
        case ($urandom_range(0, 4))
          0: f3 = 3'b000;
          1: f3 = 3'b001;
          2: f3 = 3'b010;
          3: f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
      end
      p = $urandom_range(0, 19);
      if (p == 0) a = $urandom;
      else if (p < 3) a = 32'($urandom_range(248, 263));
      else a = 32'($urandom_range(0, 255));
      do_op(we, f3, a, $urandom);
    end

    // reset in the middle of a store
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_wdata  = 32'hA1B2C3D4;
`ifdef LSU_MISALIGN_EN
    req_addr   = 32'h41;
`else
    req_addr   = 32'h40;
`endif
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
`ifdef LSU_MISALIGN_EN
    @(negedge clk);
    ref_b[8'h41] = 8'hD4;
`endif
    check("rst_mid_busy", busy, 1'b1);
    check("rst_mid_beat", mem_addr, MIS_EN ? 32'h42 : 32'h40);
    reset = 1'b1;
    #1;
    check("rst_mid_cs", mem_cs, 1'b1);
    check("rst_mid_wr", mem_wr_en, 1'b1);
    check("rst_mid_rd", mem_rd_en, 1'b0);
    check("rst_mid_mask", mem_mask, 4'b1000);
    check("rst_mid_addr", mem_addr, 32'd0);
    check("rst_mid_busy0", busy, 1'b0);
    check("rst_mid_rsp", rsp_valid, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_no_rsp", rsp_valid, 1'b0);
    end
    check("rst_ready", req_ready, 1'b1);
    do_op(1'b0, 3'b010, 32'h40, 32'h0);
    do_op(1'b0, 3'b010, 32'h44, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
